// File: rtl/exp_mant_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : exp_mant_normalizer
// Brief    : Bit-serial exponent/significand normalizer, one shift per clock.
// Revision : 1.0 - initial release
// ============================================================================
module exp_mant_normalizer #(
    parameter int W_Exp = 8,
    parameter int W_Sgf = 23
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [W_Exp-1:0]   exp_in,
    input  logic [W_Sgf+1:0]   mant_in,
    output logic [W_Exp-1:0]   exp_out,
    output logic [W_Sgf+1:0]   mant_out,
    output logic               busy,
    output logic               done,
    output logic               done_pulse
);

    localparam logic [W_Exp-1:0] c_EXP_MAX   = {W_Exp{1'b1}};
    localparam logic [W_Exp-1:0] c_EXP_ONE   = {{(W_Exp-1){1'b0}}, 1'b1};
    localparam logic [W_Exp-1:0] c_EXP_ZERO  = {W_Exp{1'b0}};
    localparam logic [W_Sgf+1:0] c_MANT_ZERO = {(W_Sgf+2){1'b0}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t           r_state;
    logic [W_Exp-1:0] r_exp;
    logic [W_Sgf+1:0] r_mant;
    logic [W_Exp-1:0] r_exp_out;
    logic [W_Sgf+1:0] r_mant_out;
    logic             r_busy;
    logic             r_done;
    logic             r_done_pulse;

    logic             w_accept;
    logic             w_mant_zero;
    logic             w_carry;
    logic             w_hidden;
    logic             w_exp_zero;
    logic [W_Exp-1:0] w_exp_inc;
    logic [W_Exp-1:0] w_exp_dec;
    logic [W_Sgf+1:0] w_mant_rsh;
    logic [W_Sgf+1:0] w_mant_lsh;

    // busy stays high through the first FINISH cycle, so a load there is ignored
    assign w_accept    = load & ~r_busy & (r_state != S_CHECK);
    assign w_mant_zero = (r_mant == c_MANT_ZERO);
    assign w_carry     = r_mant[W_Sgf+1];
    assign w_hidden    = r_mant[W_Sgf];
    assign w_exp_zero  = (r_exp == c_EXP_ZERO);
    assign w_exp_inc   = (r_exp == c_EXP_MAX) ? c_EXP_MAX : (r_exp + c_EXP_ONE);
    assign w_exp_dec   = r_exp - c_EXP_ONE;
    assign w_mant_rsh  = {1'b0, r_mant[W_Sgf+1:1]};
    assign w_mant_lsh  = {r_mant[W_Sgf:0], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_exp        <= c_EXP_ZERO;
            r_mant       <= c_MANT_ZERO;
            r_exp_out    <= c_EXP_ZERO;
            r_mant_out   <= c_MANT_ZERO;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_done_pulse <= 1'b0;
        end else begin
            r_done_pulse <= 1'b0;
            case (r_state)
                S_IDLE, S_FINISH: begin
                    if (r_state == S_FINISH && r_busy) begin
                        r_exp_out    <= r_exp;
                        r_mant_out   <= r_mant;
                        r_done       <= 1'b1;
                        r_done_pulse <= 1'b1;
                        r_busy       <= 1'b0;
                    end else if (w_accept) begin
                        r_exp   <= exp_in;
                        r_mant  <= mant_in;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_mant_zero) begin
                        r_exp   <= c_EXP_ZERO;
                        r_state <= S_FINISH;
                    end else if (w_carry) begin
                        r_mant  <= w_mant_rsh;
                        r_exp   <= w_exp_inc;
                        r_state <= S_FINISH;
                    end else if (w_hidden || w_exp_zero) begin
                        r_state <= S_FINISH;
                    end else begin
                        r_mant  <= w_mant_lsh;
                        r_exp   <= w_exp_dec;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign exp_out    = r_exp_out;
    assign mant_out   = r_mant_out;
    assign busy       = r_busy;
    assign done       = r_done;
    assign done_pulse = r_done_pulse;

endmodule
`default_nettype wire

// File: tb/tb_exp_mant_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_exp_mant_normalizer
// Brief    : Self-checking bench: arithmetic reference model plus directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exp_mant_normalizer;

    localparam int EW = 8;
    localparam int SW = 23;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [EW-1:0] exp_in = '0;
    logic [SW+1:0] mant_in = '0;
    logic [EW-1:0] exp_out;
    logic [SW+1:0] mant_out;
    logic          busy;
    logic          done;
    logic          done_pulse;

    int n_chk  = 0;
    int n_pass = 0;
    bit started = 1'b0;

    exp_mant_normalizer #(.W_Exp(EW), .W_Sgf(SW)) dut (
        .clk(clk), .rst(rst), .load(load), .exp_in(exp_in), .mant_in(mant_in),
        .exp_out(exp_out), .mant_out(mant_out), .busy(busy), .done(done),
        .done_pulse(done_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    endtask

    // Reference result from the normalization rules, as plain arithmetic
    function automatic void model(input longint e, input longint m,
                                  output longint eo, output longint mo, output int lat);
        longint emax;
        emax = (64'd1 << EW) - 1;
        lat  = 2;
        if (m == 0) begin
            eo = 0; mo = 0;
        end else if (m >= (64'd1 << (SW+1))) begin
            mo = m / 2;
            eo = (e == emax) ? emax : e + 1;
        end else begin
            eo = e; mo = m;
            while (mo < (64'd1 << SW) && eo > 0) begin
                mo = mo * 2; eo = eo - 1; lat++;
            end
        end
    endfunction

    // Cycle-level expectation: busy for lat cycles, then a held result
    longint m_eo = 0, m_mo = 0, p_eo = 0, p_mo = 0;
    int     m_left = 0, p_lat = 0;
    bit     m_busy = 0, m_done = 0, m_pulse = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_pulse = 0; m_eo = 0; m_mo = 0; m_left = 0;
        end else begin
            m_pulse = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1; m_pulse = 1; m_eo = p_eo; m_mo = p_mo;
                end
            end else if (load) begin
                model(longint'(exp_in), longint'(mant_in), p_eo, p_mo, p_lat);
                m_left = p_lat; m_busy = 1; m_done = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("busy", longint'(busy), longint'(m_busy));
            chk("done", longint'(done), longint'(m_done));
            chk("done_pulse", longint'(done_pulse), longint'(m_pulse));
            if (m_done) begin
                chk("exp_out", longint'(exp_out), m_eo);
                chk("mant_out", longint'(mant_out), m_mo);
                chk("carry_bit_clear", longint'(mant_out[SW+1]), 0);
            end
        end
    end

    task automatic launch(input logic [EW-1:0] e, input logic [SW+1:0] m);
        exp_in = e; mant_in = m; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic wait_done(input int start, output int n);
        n = start;
        while (done !== 1'b1 && n < 64) begin
            @(posedge clk); #1; n++;
        end
        if (done !== 1'b1) chk("done_timeout", 0, 1);
    endtask

    task automatic run(input string nm, input logic [EW-1:0] e, input logic [SW+1:0] m,
                       input logic [EW-1:0] ee, input logic [SW+1:0] em, input int el);
        int n;
        launch(e, m);
        wait_done(0, n);
        chk({nm, "_latency"}, n, el);
        chk({nm, "_exp"}, longint'(exp_out), longint'(ee));
        chk({nm, "_mant"}, longint'(mant_out), longint'(em));
        chk({nm, "_pulse"}, longint'(done_pulse), 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int n;
        @(posedge clk); #1;
        started = 1'b1;
        idle(2);
        chk("rst_exp_out", longint'(exp_out), 0);
        chk("rst_mant_out", longint'(mant_out), 0);
        chk("rst_flags", longint'({busy, done, done_pulse}), 0);
        rst = 1'b0;
        idle(2);

        run("normalized", 8'h80, 25'h0800000, 8'h80, 25'h0800000, 2);
        run("carry",      8'h7F, 25'h1800001, 8'h80, 25'h0C00000, 2); // back-to-back
        idle(1);
        run("carry_sat",  8'hFF, 25'h1800001, 8'hFF, 25'h0C00000, 2);
        idle(3);
        run("lshift",     8'h10, 25'h0100000, 8'h0D, 25'h0800000, 5);
        run("denormal",   8'h02, 25'h0000100, 8'h00, 25'h0000400, 4);
        idle(2);
        run("zero",       8'h55, 25'h0000000, 8'h00, 25'h0000000, 2);
        run("worst",      8'h80, 25'h0000001, 8'h69, 25'h0800000, 25);
        run("exp_zero",   8'h00, 25'h0000400, 8'h00, 25'h0000400, 2);
        idle(2);

        // Second load mid-operation must be ignored
        launch(8'h10, 25'h0100000);
        @(posedge clk); #1;
        exp_in = 8'h40; mant_in = 25'h1000000; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        wait_done(2, n);
        chk("ignored_load_latency", n, 5);
        chk("ignored_load_exp", longint'(exp_out), 8'h0D);
        chk("ignored_load_mant", longint'(mant_out), 25'h0800000);
        idle(2);

        // Reset mid-operation aborts with no result
        launch(8'h10, 25'h0100000);
        idle(2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_exp_out", longint'(exp_out), 0);
        chk("abort_mant_out", longint'(mant_out), 0);
        chk("abort_flags", longint'({busy, done, done_pulse}), 0);
        idle(6);
        chk("abort_still_idle", longint'({busy, done}), 0);

        run("after_rst", 8'h7F, 25'h1800001, 8'h80, 25'h0C00000, 2);
        idle(3);

        started = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/exp_mant_normalizer.md
# exp_mant_normalizer

Sequential normalization stage of the floating-point datapath. It sits directly upstream of the overflow/underflow detection stage. It takes an unnormalized significand with its carry bit, plus the biased exponent, and normalizes them one bit per clock. It then presents the adjusted exponent with a one-cycle load strobe that the detection stage uses as its register-load control.

## Interface
Parameters:
- W_Exp, default 8: exponent width (8 single, 11 double).
- W_Sgf, default 23: fraction width (23 single, 52 double).

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst, input, 1: reset.
  - Synchronous, active-high.
  - Returns the block to IDLE and zeroes every output register.
- load, input, 1: start strobe; sampled only when busy=0.
- exp_in, input, W_Exp: biased exponent.
- mant_in, input, W_Sgf+2: significand.
  - Bit W_Sgf+1 is the carry/overflow bit.
  - Bit W_Sgf is the hidden bit.
- exp_out, output, W_Exp: normalized exponent; feeds the detection stage's exponent input.
- mant_out, output, W_Sgf+2: normalized significand; bit W_Sgf+1 is always 0 when done=1.
- busy, output, 1: high from the cycle after load is accepted until done rises.
- done, output, 1: result valid. Held high until the next accepted load or rst.
- done_pulse, output, 1: one-cycle strobe coincident with the rising edge of done; drives the detection stage's ctrl.

## Operation
- Reset values: exp_out=0, mant_out=0, busy=0, done=0, done_pulse=0, state=IDLE.
- States: IDLE, CHECK, FINISH.
- IDLE or FINISH, load=1:
  - Capture exp_in and mant_in into the working registers.
  - Clear done.
  - Set busy.
  - Go to CHECK.
- CHECK evaluates in priority order, one decision per cycle:
  1. mant==0: force exp=0 and go to FINISH (exact zero).
  2. mant[W_Sgf+1]==1: mant>>=1 with the LSB discarded (truncation), exp+=1, then go to FINISH. If exp is already all-ones it stays all-ones, which saturates the exponent.
  3. mant[W_Sgf]==1: go to FINISH unchanged.
  4. exp==0: go to FINISH unchanged (denormal; no further shift).
  5. Otherwise: mant<<=1 with 0 shifted in, exp-=1, stay in CHECK.
- FINISH, on entry:
  - Copy the working registers to exp_out and mant_out.
  - done=1 and done_pulse=1 for exactly one cycle.
  - busy=0.
  - Stay in FINISH until load.
- Width rules:
  - The exponent never wraps. The increment saturates at 2^W_Exp-1; the decrement stops at 0 (rule 4).
  - An exp_out of all-ones is reported as overflow downstream. An exp_out of 0 is reported as underflow downstream.
- load while busy=1 is ignored. The captured operands are unaffected.
- load in the same cycle as FINISH entry cannot occur, because busy is still 1 that cycle, so load is ignored.
- rst has priority over everything. Asserted mid-operation, it aborts the operation, and done_pulse is not generated.

## Timing
- load sampled high at edge k moves the block to CHECK after edge k.
- Already-normalized operand, carry case, or zero: outputs valid and done/done_pulse high after edge k+2.
- Left shift by s positions: done after edge k+2+s. The worst case is s=W_Sgf (only the LSB set, exp large): 2+W_Sgf cycles.
- exp_out and mant_out are registered and stable for as long as done=1.
- done_pulse is high for exactly one cycle per accepted load. The detection stage therefore registers its flags at the edge following done_pulse.
- A back-to-back load is legal in the first cycle done=1. done drops the next cycle.

## Test plan
- Already normalized: exp_in=8'h80, mant_in=25'h0800000, load. Required: after 2 cycles exp_out=8'h80, mant_out=25'h0800000, one-cycle done_pulse.
- Carry and saturation:
  - mant_in=25'h1800001, exp_in=8'h7F. Required: mant_out=25'h0C00000, exp_out=8'h80, 2-cycle latency.
  - Repeat with exp_in=8'hFF. Required: exp_out=8'hFF.
- Left shift: exp_in=8'h10, mant_in=25'h0100000 (needs 3 shifts). Required: exp_out=8'h0D, mant_out=25'h0800000, done after 5 cycles, busy high for cycles 1-4.
- Denormal stop: exp_in=8'h02, mant_in=25'h0000100. Required: two shifts then stop, giving exp_out=8'h00 and mant_out=25'h0000400.
- Zero operand: mant_in=0, exp_in=8'h55. Required: exp_out=8'h00, mant_out=0, done after 2 cycles.
- Protocol:
  - Assert load again at cycle 2 of a 5-cycle operation. Required: ignored, and the original result is unaltered.
  - Assert rst at cycle 3 of an operation. Required: next cycle all outputs 0, state IDLE, no done_pulse.
  - A new load after reset completes normally.
